gen_debug_mux_sequencer: RTL
============================

# gen_debug_mux_sequencer

Controller for the multicycle debug data mux. It sweeps the mux selector over a programmed index range and holds each selector value stable for a configurable number of cycles, so the mux output path can be constrained as multicycle. It then captures the settled mux word and presents it on a valid/ready stream. It sits between the debug register/readout logic (start, range, abort) and the mux (`in_data_sel` / `out_data_bus`).

## Interface
Parameters:
- `DATA_SEL_OPTIONS`, 12: number of selectable 32-bit words in the mux; legal indices are 0..DATA_SEL_OPTIONS-1.
- `OUT_DATA_BUS_WIDTH`, 32: width of the mux output word and of `dout`.
- `MC_CYCLES`, 3: number of cycles the selector is held before capture. Minimum 2, which is the mux's two register stages.
- Localparam `DATA_SEL_WIDTH` = $clog2(DATA_SEL_OPTIONS).

Ports:
- `clk` in 1: single clock, shared with the mux.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to begin a sweep; sampled only in IDLE.
- `start_sel` in DATA_SEL_WIDTH: first index of the sweep, sampled with `start`.
- `end_sel` in DATA_SEL_WIDTH: last index of the sweep (inclusive), sampled with `start`.
- `abort` in 1: terminates any sweep; takes effect next cycle.
- `mux_sel` out DATA_SEL_WIDTH: registered selector, drives the mux `in_data_sel`.
- `mux_data` in OUT_DATA_BUS_WIDTH: from the mux `out_data_bus`.
- `dout` out OUT_DATA_BUS_WIDTH: captured word, stable while `dout_valid` is high.
- `dout_sel` out DATA_SEL_WIDTH: index of the word currently on `dout`.
- `dout_valid` out 1 / `dout_ready` in 1: output handshake.
- `busy` out 1: high in every state other than IDLE.
- `done` out 1: one-cycle pulse when the last word of a sweep is accepted.
- `err` out 1: one-cycle pulse when a start request is rejected.

## Operation
States and transitions:
- **IDLE**
  - A legal `start` (start_sel ≤ end_sel, and end_sel < DATA_SEL_OPTIONS) does the following: `mux_sel`←start_sel, stores end_sel, sets settle counter ← MC_CYCLES-1, and moves to SETTLE.
  - An illegal `start` pulses `err` and stays in IDLE.
- **SETTLE**
  - `mux_sel` is held constant; the counter decrements each cycle.
  - In the cycle the counter is 0: `dout`←mux_data, `dout_sel`←mux_sel, `dout_valid`←1, and the state moves to PRESENT.
- **PRESENT**
  - `dout`, `dout_sel` and `mux_sel` are held.
  - On `dout_valid && dout_ready`, `dout_valid` drops.
    - If mux_sel == stored end_sel: pulse `done` and move to IDLE.
    - Otherwise: `mux_sel`←mux_sel+1, counter ← MC_CYCLES-1, and move to SETTLE.
- **abort** in any state: next state is IDLE, `dout_valid`←0, no `done` pulse. `mux_sel` and `dout` keep their last values.

Rules:
- `start` while busy is ignored, with no `err` pulse.
- abort and start in the same IDLE cycle: abort wins and the start is dropped.
- abort in PRESENT coinciding with a handshake: the word counts as transferred, and there is still no `done` pulse.
- `mux_sel` never changes outside the IDLE→SETTLE and PRESENT→SETTLE transitions. This is the guarantee behind the multicycle constraint.
- `mux_sel` increments without wrap, since end_sel < DATA_SEL_OPTIONS.
- Single-word sweep (start_sel == end_sel) is legal.

## Timing
- Reset values: `mux_sel`=0, `dout`=0, `dout_sel`=0, `dout_valid`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Legal `start` in cycle T:
  - `mux_sel` and `busy` are valid at T+1.
  - Capture happens at the end of T+MC_CYCLES.
  - `dout_valid` rises at T+MC_CYCLES+1.
- With `dout_ready` held high, each word takes MC_CYCLES+1 cycles from selector change to acceptance.
- A sweep of N words with `dout_ready` held high finishes in N·(MC_CYCLES+1) cycles after `start`. `done` is high in the acceptance cycle of the last word, and `busy` is low the cycle after.
- `err` is high in cycle T+1 for an illegal start in cycle T.
- `rst` asserted mid-sweep returns every output to its reset value on the next edge.

## Configuration
- `GEN_DEBUG_MUX_SEQ_CONT_EN` defined:
  - Adds input `cont_mode` (1 bit), sampled with `start`.
  - When set, acceptance of the end_sel word reloads `mux_sel`←start_sel and goes to SETTLE instead of IDLE. `done` is never pulsed, and the sweep repeats until `abort`.
- Undefined: the port is absent and every sweep is one-shot.

## Test plan
- Reset, then start with start_sel=0, end_sel=3, `dout_ready`=1, MC_CYCLES=3, mux model returning 0xA0+sel → `dout` = 0xA0..0xA3, `dout_sel` = 0..3, `dout_valid` first at T+4, `done` on the 4th acceptance at T+16.
- Same sweep with `dout_ready` low for 5 cycles on word 1 → `dout`=0xA1 and `mux_sel`=1 held stable; no selector change during the stall.
- start_sel=5, end_sel=2, then start_sel=0 with end_sel=DATA_SEL_OPTIONS → `err` pulse each time, `busy` stays 0.
- Sweep 0..7 with `abort` asserted in SETTLE of word 2 → `dout_valid` never rises for word 2, IDLE next cycle, no `done`. A new start is accepted immediately after.
- Single word sel=11 → one transfer of 0xAB, then `done`. `start` pulsed while busy is ignored.
- With `GEN_DEBUG_MUX_SEQ_CONT_EN`, `cont_mode`=1, range 2..3 → sequence 2,3,2,3,… with no `done` until `abort`. Assert `rst` mid-word → all outputs read 0 next cycle.

Source files
------------

// File: rtl/gen_debug_mux_sequencer_if.sv
// Stream/control bundle between the debug readout logic, the multicycle
// debug data mux and gen_debug_mux_sequencer.
// Optional macro GEN_DEBUG_MUX_SEQ_CONT_EN adds the cont_mode signal.
interface gen_debug_mux_sequencer_if #(
    parameter int unsigned DATA_SEL_WIDTH     = 4,
    parameter int unsigned OUT_DATA_BUS_WIDTH = 32
);
    logic                          start;
    logic [DATA_SEL_WIDTH-1:0]     start_sel;
    logic [DATA_SEL_WIDTH-1:0]     end_sel;
    logic                          abort;
`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
    logic                          cont_mode;
`endif
    logic [DATA_SEL_WIDTH-1:0]     mux_sel;
    logic [OUT_DATA_BUS_WIDTH-1:0] mux_data;
    logic [OUT_DATA_BUS_WIDTH-1:0] dout;
    logic [DATA_SEL_WIDTH-1:0]     dout_sel;
    logic                          dout_valid;
    logic                          dout_ready;
    logic                          busy;
    logic                          done;
    logic                          err;

    modport master (
`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
        output cont_mode,
`endif
        output start, start_sel, end_sel, abort, mux_data, dout_ready,
        input  mux_sel, dout, dout_sel, dout_valid, busy, done, err
    );

    modport slave (
`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
        input  cont_mode,
`endif
        input  start, start_sel, end_sel, abort, mux_data, dout_ready,
        output mux_sel, dout, dout_sel, dout_valid, busy, done, err
    );
endinterface

// File: rtl/gen_debug_mux_sequencer.sv
// Sweeps the debug mux selector over [start_sel, end_sel], holds each
// selector for MC_CYCLES cycles (minimum 2, the mux's register depth),
// captures the settled word and hands it out on a valid/ready stream.
// Optional macro GEN_DEBUG_MUX_SEQ_CONT_EN: cont_mode repeats the sweep
// until abort instead of finishing with done.
module gen_debug_mux_sequencer #(
    parameter int unsigned DATA_SEL_OPTIONS   = 12,
    parameter int unsigned OUT_DATA_BUS_WIDTH = 32,
    parameter int unsigned MC_CYCLES          = 3
) (
    input logic                   clk,
    input logic                   rst,
    gen_debug_mux_sequencer_if.slave bus
);
    localparam int unsigned DATA_SEL_WIDTH = $clog2(DATA_SEL_OPTIONS);
    localparam int unsigned CNT_WIDTH      = $clog2(MC_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT
    } state_t;

    state_t                    state;
    logic [DATA_SEL_WIDTH-1:0] end_q;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      cont_q;
    logic                      start_ok;
    logic                      last_word;
    logic                      accept;

`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
    logic [DATA_SEL_WIDTH-1:0] start_q;
`else
    assign cont_q = 1'b0;
`endif

    // Request legality and handshake decode for the current cycle.
    always_comb begin
        start_ok  = (bus.start_sel <= bus.end_sel) &&
                    (32'(bus.end_sel) < DATA_SEL_OPTIONS);
        accept    = (state == PRESENT) && bus.dout_valid && bus.dout_ready;
        last_word = (bus.mux_sel == end_q);
    end

    // done must coincide with acceptance of the last word, so it is decoded
    // from the live handshake rather than registered.
    assign bus.done = accept && last_word && !cont_q && !bus.abort;

    // Sequencer FSM; mux_sel only moves on entry to SETTLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            end_q          <= '0;
            cnt            <= '0;
            bus.mux_sel    <= '0;
            bus.dout       <= '0;
            bus.dout_sel   <= '0;
            bus.dout_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b0;
`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
            cont_q         <= 1'b0;
            start_q        <= '0;
`endif
        end else begin
            bus.err <= 1'b0;
            if (bus.abort) begin
                state          <= IDLE;
                bus.dout_valid <= 1'b0;
                bus.busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if (start_ok) begin
                                bus.mux_sel <= bus.start_sel;
                                end_q       <= bus.end_sel;
                                cnt         <= CNT_WIDTH'(MC_CYCLES - 1);
                                bus.busy    <= 1'b1;
                                state       <= SETTLE;
`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
                                cont_q      <= bus.cont_mode;
                                start_q     <= bus.start_sel;
`endif
                            end else begin
                                bus.err <= 1'b1;
                            end
                        end
                    end
                    SETTLE: begin
                        if (cnt == '0) begin
                            bus.dout       <= OUT_DATA_BUS_WIDTH'(bus.mux_data);
                            bus.dout_sel   <= bus.mux_sel;
                            bus.dout_valid <= 1'b1;
                            state          <= PRESENT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (accept) begin
                            bus.dout_valid <= 1'b0;
                            if (last_word && !cont_q) begin
                                bus.busy <= 1'b0;
                                state    <= IDLE;
                            end else begin
`ifdef GEN_DEBUG_MUX_SEQ_CONT_EN
                                bus.mux_sel <= last_word ? start_q : bus.mux_sel + 1'b1;
`else
                                bus.mux_sel <= bus.mux_sel + 1'b1;
`endif
                                cnt   <= CNT_WIDTH'(MC_CYCLES - 1);
                                state <= SETTLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
